// File: rtl/axil_ctrl_slave.sv
// ---------------------------------------------------------------------------
// axil_ctrl_slave
//   AXI4-Lite control slave for a start/done style kernel. Holds a CTRL
//   register (start request, sticky done, live idle) and NUM_ARGS 32-bit
//   argument registers that are presented to the kernel in parallel.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_aw* / s_w* / s_b*      AXI4-Lite write address / data / response
//   s_ar* / s_r*             AXI4-Lite read address / data
//   ap_start  (out)          kernel start request, held until ap_ready
//   ap_ready  (in)           kernel accepted start (pulse)
//   ap_done   (in)           kernel finished (pulse), latched as done_sticky
//   ap_idle   (in)           kernel idle level, visible in CTRL bit 3
//   args      (out)          argument registers, arg i on [32*i+31:32*i]
//
// Address map (only address bits [7:0] are decoded)
//   0x00          CTRL  {28'b0, idle, 1'b0, done_sticky, start}
//   0x10 + 4*i    ARG i (i < NUM_ARGS)
//   anything else unmapped: SLVERR, reads return 0, writes ignored
// ---------------------------------------------------------------------------
module axil_ctrl_slave #(
   parameter int unsigned S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned NUM_ARGS         = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   // write address channel
   input  logic [S_AXI_ADDR_WIDTH-1:0] s_awaddr,
   input  logic                        s_awvalid,
   output logic                        s_awready,
   // write data channel
   input  logic [31:0]                 s_wdata,
   input  logic [3:0]                  s_wstrb,
   input  logic                        s_wvalid,
   output logic                        s_wready,
   // write response channel
   output logic [1:0]                  s_bresp,
   output logic                        s_bvalid,
   input  logic                        s_bready,
   // read address channel
   input  logic [S_AXI_ADDR_WIDTH-1:0] s_araddr,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   // read data channel
   output logic [31:0]                 s_rdata,
   output logic [1:0]                  s_rresp,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   // kernel control
   output logic                        ap_start,
   input  logic                        ap_ready,
   input  logic                        ap_done,
   input  logic                        ap_idle,
   output logic [NUM_ARGS*32-1:0]      args
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_ADDR,
      W_WAIT,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_ADDR,
      R_DATA
   } rstate_t;

   // ------------------------------------------------------------------
   // Address decode helpers
   // ------------------------------------------------------------------
   function automatic logic is_arg_addr(input logic [7:0] a);
      return (a >= 8'h10) && (a[1:0] == 2'b00) &&
             ({24'b0, a} < (32'd16 + 32'd4 * NUM_ARGS));
   endfunction

   function automatic logic [3:0] arg_index(input logic [7:0] a);
      return 4'(a[7:2] - 6'd4);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   wstate_t                 wstate_q;
   logic                    awready_q, wready_q, bvalid_q;
   logic [1:0]              bresp_q;
   logic                    aw_got_q, w_got_q;
   logic [7:0]              awaddr_q;
   logic [31:0]             wdata_q;
   logic [3:0]              wstrb_q;

   rstate_t                 rstate_q;
   logic                    arready_q, rvalid_q;
   logic [31:0]             rdata_q;
   logic [1:0]              rresp_q;

   logic [NUM_ARGS*32-1:0]  args_q;
   logic                    ap_start_q;
   logic                    done_sticky_q;

   // ------------------------------------------------------------------
   // Write-side combinational decode
   // ------------------------------------------------------------------
   logic        aw_hs, w_hs, wr_commit;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_is_ctrl, wr_is_arg;
   logic [3:0]  wr_idx;

   always_comb begin
      aw_hs = s_awvalid & awready_q;
      w_hs  = s_wvalid & wready_q;
      // A channel captured earlier in W_WAIT supplies its latched copy;
      // the channel completing now is taken straight from the bus.
      wr_addr = aw_got_q ? awaddr_q : s_awaddr[7:0];
      wr_data = w_got_q  ? wdata_q  : s_wdata;
      wr_strb = w_got_q  ? wstrb_q  : s_wstrb;
      wr_commit = 1'b0;
      case (wstate_q)
         W_ADDR:  wr_commit = aw_hs & w_hs;
         W_WAIT:  wr_commit = aw_got_q ? w_hs : aw_hs;
         default: wr_commit = 1'b0;
      endcase
      wr_is_ctrl = (wr_addr == 8'h00);
      wr_is_arg  = is_arg_addr(wr_addr);
      wr_idx     = arg_index(wr_addr);
   end

   // ------------------------------------------------------------------
   // Read-side combinational decode
   // ------------------------------------------------------------------
   logic        ar_hs;
   logic [7:0]  rd_addr;
   logic        rd_is_ctrl, rd_is_arg;
   logic [3:0]  rd_idx;
   logic [31:0] rd_value;

   always_comb begin
      ar_hs      = s_arvalid & arready_q;
      rd_addr    = s_araddr[7:0];
      rd_is_ctrl = (rd_addr == 8'h00);
      rd_is_arg  = is_arg_addr(rd_addr);
      rd_idx     = arg_index(rd_addr);
      rd_value   = '0;
      if (rd_is_ctrl) begin
         rd_value = {28'b0, ap_idle, 1'b0, done_sticky_q, ap_start_q};
      end else begin
         for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            if (rd_is_arg && ({28'b0, rd_idx} == i)) begin
               rd_value = args_q[32*i +: 32];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Write FSM
   // Ready flags reset low and are raised on the first clock after
   // release, so nothing is accepted while rst is asserted.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q  <= W_ADDR;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wstate_q)
            W_ADDR: begin
               if (wr_commit) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= (wr_is_ctrl | wr_is_arg) ? RESP_OKAY : RESP_SLVERR;
               end else if (aw_hs) begin
                  wstate_q  <= W_WAIT;
                  awaddr_q  <= s_awaddr[7:0];
                  aw_got_q  <= 1'b1;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (w_hs) begin
                  wstate_q  <= W_WAIT;
                  wdata_q   <= s_wdata;
                  wstrb_q   <= s_wstrb;
                  w_got_q   <= 1'b1;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_WAIT: begin
               if (wr_commit) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= (wr_is_ctrl | wr_is_arg) ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  wstate_q  <= W_ADDR;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  aw_got_q  <= 1'b0;
                  w_got_q   <= 1'b0;
               end
            end
            default: begin
               wstate_q  <= W_ADDR;
               bvalid_q  <= 1'b0;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               aw_got_q  <= 1'b0;
               w_got_q   <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate_q  <= R_ADDR;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (rstate_q)
            R_ADDR: begin
               if (ar_hs) begin
                  rstate_q  <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_value;
                  rresp_q   <= (rd_is_ctrl | rd_is_arg) ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  rstate_q  <= R_ADDR;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: begin
               rstate_q  <= R_ADDR;
               rvalid_q  <= 1'b0;
               arready_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Control and argument registers
   // A start-setting write wins over a same-cycle ap_ready; a same-cycle
   // ap_done wins over the clear-on-read, so no completion is lost.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         args_q        <= '0;
         ap_start_q    <= 1'b0;
         done_sticky_q <= 1'b0;
      end else begin
         if (wr_commit && wr_is_arg) begin
            for (int unsigned i = 0; i < NUM_ARGS; i++) begin
               for (int unsigned b = 0; b < 4; b++) begin
                  if (({28'b0, wr_idx} == i) && wr_strb[b]) begin
                     args_q[32*i + 8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end

         if (wr_commit && wr_is_ctrl && wr_data[0]) begin
            ap_start_q <= 1'b1;
         end else if (ap_ready) begin
            ap_start_q <= 1'b0;
         end

         if (ap_done) begin
            done_sticky_q <= 1'b1;
         end else if (ar_hs && rd_is_ctrl) begin
            done_sticky_q <= 1'b0;
         end
      end
   end

   // Only address bits [7:0] take part in decoding.
   generate
      if (S_AXI_ADDR_WIDTH > 8) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^{s_awaddr[S_AXI_ADDR_WIDTH-1:8],
                                   s_araddr[S_AXI_ADDR_WIDTH-1:8]};
      end
   endgenerate

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign ap_start  = ap_start_q;
   assign args      = args_q;

endmodule

// File: tb/tb_axil_ctrl_slave.sv
module tb_axil_ctrl_slave;

   localparam int unsigned NARGS = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [31:0]          s_awaddr;
   logic                 s_awvalid;
   logic                 s_awready;
   logic [31:0]          s_wdata;
   logic [3:0]           s_wstrb;
   logic                 s_wvalid;
   logic                 s_wready;
   logic [1:0]           s_bresp;
   logic                 s_bvalid;
   logic                 s_bready;
   logic [31:0]          s_araddr;
   logic                 s_arvalid;
   logic                 s_arready;
   logic [31:0]          s_rdata;
   logic [1:0]           s_rresp;
   logic                 s_rvalid;
   logic                 s_rready;
   logic                 ap_start;
   logic                 ap_ready;
   logic                 ap_done;
   logic                 ap_idle;
   logic [NARGS*32-1:0]  args;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_args [NARGS];
   logic        m_start;
   logic        m_done;

   always #5 clk = ~clk;

   axil_ctrl_slave #(
      .S_AXI_ADDR_WIDTH(32),
      .NUM_ARGS(NARGS)
   ) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
      .args(args)
   );

   // ------------------------------------------------------------------
   // Reference model (address map arithmetic on byte offsets)
   // ------------------------------------------------------------------
   function automatic bit m_is_arg(input logic [7:0] a);
      int off;
      off = int'(a) - 16;
      return (off >= 0) && (off % 4 == 0) && (off / 4 < int'(NARGS));
   endfunction

   function automatic logic [1:0] m_resp(input logic [7:0] a);
      return ((a == 8'h00) || m_is_arg(a)) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      if (a == 8'h00) return {28'b0, ap_idle, 1'b0, m_done, m_start};
      if (m_is_arg(a)) return m_args[(int'(a) - 16) / 4];
      return 32'h0;
   endfunction

   function automatic logic [NARGS*32-1:0] m_flat();
      logic [NARGS*32-1:0] f;
      for (int i = 0; i < int'(NARGS); i++) f[32*i +: 32] = m_args[i];
      return f;
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a == 8'h00) begin
         if (d[0]) m_start = 1'b1;
      end else if (m_is_arg(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_args[(int'(a) - 16) / 4][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NARGS); i++) m_args[i] = 32'h0;
      m_start = 1'b0;
      m_done  = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Bus drivers (bounded waits; an expired bound counts as a failure)
   // ------------------------------------------------------------------
   task automatic do_aw_w(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
      int cyc;
      bit aw_done, w_done;
      cyc = 0; aw_done = 0; w_done = 0;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         s_awvalid = !aw_done && (cyc >= aw_dly);
         s_wvalid  = !w_done && (cyc >= w_dly);
         @(negedge clk);
         if (s_awvalid && s_awready) aw_done = 1;
         if (s_wvalid && s_wready) w_done = 1;
         @(posedge clk); #1;
         cyc++;
      end
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         n_checks++; n_fail++;
         $display("FAIL aw_w_timeout: aw_done=%0d w_done=%0d, required 1 1", aw_done, w_done);
      end
   endtask

   task automatic do_b(input int b_dly, output logic [1:0] resp);
      int t;
      t = 0;
      while (!s_bvalid && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (!s_bvalid) begin
         n_checks++; n_fail++;
         $display("FAIL b_timeout: bvalid=%b, required 1", s_bvalid);
      end
      resp = s_bresp;
      repeat (b_dly) begin @(posedge clk); #1; end
      s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      int t;
      bit hs;
      t = 0; hs = 0;
      s_araddr = addr; s_arvalid = 1'b1;
      while (!hs && t < 40) begin
         @(negedge clk);
         if (s_arready) hs = 1;
         @(posedge clk); #1; t++;
      end
      s_arvalid = 1'b0;
      while (!s_rvalid && t < 60) begin
         @(posedge clk); #1; t++;
      end
      if (!s_rvalid) begin
         n_checks++; n_fail++;
         $display("FAIL r_timeout: rvalid=%b, required 1", s_rvalid);
      end
      data = s_rdata; resp = s_rresp;
      repeat (r_dly) begin @(posedge clk); #1; end
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({s_awready, s_wready, s_arready} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ready_low: got %b, required 000", {s_awready, s_wready, s_arready});
      end
      n_checks++;
      if ({s_bvalid, s_rvalid, ap_start} !== 3'b000) begin
         n_fail++; $display("FAIL reset_valid_low: bvalid/rvalid/start got %b, required 000", {s_bvalid, s_rvalid, ap_start});
      end
      n_checks++;
      if (args !== '0 || s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
         n_fail++; $display("FAIL reset_regs: args=%h rdata=%h bresp=%b rresp=%b, required all 0", args, s_rdata, s_bresp, s_rresp);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({s_awready, s_wready, s_arready} !== 3'b111) begin
         n_fail++; $display("FAIL reset_release_ready: got %b, required 111", {s_awready, s_wready, s_arready});
      end
   endtask

   task automatic test_same_cycle();
      logic [1:0] resp;
      do_aw_w(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      model_write(8'h10, 32'hDEAD_BEEF, 4'hF);
      n_checks++;
      if (s_bvalid !== 1'b1) begin
         n_fail++; $display("FAIL same_cycle_bvalid_latency: bvalid=%b, required 1", s_bvalid);
      end
      n_checks++;
      if (args[31:0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL same_cycle_arg0: got %h, required deadbeef", args[31:0]);
      end
      n_checks++;
      if ({s_awready, s_wready} !== 2'b00) begin
         n_fail++; $display("FAIL same_cycle_ready_in_resp: got %b, required 00", {s_awready, s_wready});
      end
      do_b(0, resp);
      n_checks++;
      if (resp !== 2'b00) begin
         n_fail++; $display("FAIL same_cycle_bresp: got %b, required 00", resp);
      end
   endtask

   task automatic test_w_first();
      logic [1:0] resp;
      do_aw_w(32'h0000_0014, 32'h1234_5678, 4'h3, 2, 0);
      model_write(8'h14, 32'h1234_5678, 4'h3);
      n_checks++;
      if (s_bvalid !== 1'b1) begin
         n_fail++; $display("FAIL w_first_bvalid_latency: bvalid=%b, required 1", s_bvalid);
      end
      n_checks++;
      if (args[63:32] !== 32'h0000_5678) begin
         n_fail++; $display("FAIL w_first_arg1: got %h, required 00005678", args[63:32]);
      end
      // offer a further write while the response is stalled
      s_awaddr = 32'h18; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({s_bvalid, s_awready, s_wready} !== 3'b100) begin
            n_fail++; $display("FAIL w_first_stall_%0d: bvalid/awready/wready got %b, required 100", k, {s_bvalid, s_awready, s_wready});
         end
         @(posedge clk); #1;
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      do_b(0, resp);
      n_checks++;
      if (resp !== 2'b00) begin
         n_fail++; $display("FAIL w_first_bresp: got %b, required 00", resp);
      end
      n_checks++;
      if (args !== m_flat()) begin
         n_fail++; $display("FAIL w_first_args: got %h, required %h", args, m_flat());
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] hi, data, rd, addr;
         logic [7:0]  wb, rb;
         logic [3:0]  strb;
         logic [1:0]  resp;
         hi = $urandom();
         if ($urandom_range(0, 9) < 7) wb = 8'h10 + 8'(4 * $urandom_range(0, NARGS - 1));
         else wb = 8'($urandom_range(1, 255));
         data = $urandom();
         strb = 4'($urandom_range(0, 15));
         addr = {hi[31:8], wb};
         do_aw_w(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3));
         model_write(wb, data, strb);
         n_checks++;
         if (s_bvalid !== 1'b1) begin
            n_fail++; $display("FAIL rand_bvalid_latency[%0d]: bvalid=%b, required 1", n, s_bvalid);
         end
         do_b($urandom_range(0, 2), resp);
         n_checks++;
         if (resp !== m_resp(wb)) begin
            n_fail++; $display("FAIL rand_bresp[%0d] addr=%h: got %b, required %b", n, wb, resp, m_resp(wb));
         end
         n_checks++;
         if (args !== m_flat()) begin
            n_fail++; $display("FAIL rand_args[%0d]: got %h, required %h", n, args, m_flat());
         end
         if ($urandom_range(0, 1) == 0) rb = wb;
         else rb = 8'h10 + 8'(4 * $urandom_range(0, NARGS - 1));
         hi = $urandom();
         do_read({hi[31:8], rb}, $urandom_range(0, 2), rd, resp);
         n_checks++;
         if (rd !== m_read(rb) || resp !== m_resp(rb)) begin
            n_fail++; $display("FAIL rand_read[%0d] addr=%h: got %h/%b, required %h/%b", n, rb, rd, resp, m_read(rb), m_resp(rb));
         end
      end
   endtask

   task automatic test_rdata_stable();
      logic [31:0] d0;
      int t;
      t = 0;
      s_araddr = 32'hABCD_0010; s_arvalid = 1'b1;
      @(negedge clk);
      while (!s_arready && t < 20) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      d0 = s_rdata;
      n_checks++;
      if (s_rvalid !== 1'b1 || d0 !== m_args[0]) begin
         n_fail++; $display("FAIL stable_first: rvalid=%b rdata=%h, required 1 %h", s_rvalid, d0, m_args[0]);
      end
      // overwrite the register being read while the read data is held
      s_awaddr = 32'h10; s_wdata = ~d0; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      model_write(8'h10, ~d0, 4'hF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (s_rvalid !== 1'b1 || s_rdata !== d0) begin
            n_fail++; $display("FAIL stable_hold_%0d: rvalid=%b rdata=%h, required 1 %h", k, s_rvalid, s_rdata, d0);
         end
         @(posedge clk); #1;
      end
      s_rready = 1'b1; s_bready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0; s_bready = 1'b0;
      n_checks++;
      if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0 || args !== m_flat()) begin
         n_fail++; $display("FAIL stable_after: rvalid=%b bvalid=%b args=%h, required 0 0 %h", s_rvalid, s_bvalid, args, m_flat());
      end
   endtask

   task automatic test_start();
      logic [1:0]  resp;
      logic [31:0] rd;
      ap_idle = 1'b0;
      do_aw_w(32'h0, 32'h1, 4'hF, 0, 0);
      model_write(8'h00, 32'h1, 4'hF);
      do_b(0, resp);
      n_checks++;
      if (resp !== 2'b00) begin
         n_fail++; $display("FAIL start_bresp: got %b, required 00", resp);
      end
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (ap_start !== 1'b1) begin
            n_fail++; $display("FAIL start_held_%0d: got %b, required 1", k, ap_start);
         end
         @(posedge clk); #1;
      end
      ap_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ap_start !== 1'b1) begin
         n_fail++; $display("FAIL start_during_ready: got %b, required 1", ap_start);
      end
      @(posedge clk); #1;
      ap_ready = 1'b0;
      m_start = 1'b0;
      n_checks++;
      if (ap_start !== 1'b0) begin
         n_fail++; $display("FAIL start_cleared: got %b, required 0", ap_start);
      end
      do_read(32'h0, 0, rd, resp);
      n_checks++;
      if (rd !== m_read(8'h00) || rd[0] !== 1'b0) begin
         n_fail++; $display("FAIL start_ctrl_read: got %h, required %h", rd, m_read(8'h00));
      end
      // start-setting write coincident with ap_ready keeps start set
      s_awaddr = 32'h0; s_wdata = 32'h1; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; ap_ready = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; ap_ready = 1'b0;
      m_start = 1'b1;
      n_checks++;
      if (ap_start !== 1'b1 || s_bvalid !== 1'b1) begin
         n_fail++; $display("FAIL start_vs_ready: start=%b bvalid=%b, required 1 1", ap_start, s_bvalid);
      end
      do_b(0, resp);
      ap_ready = 1'b1;
      @(posedge clk); #1;
      ap_ready = 1'b0;
      m_start = 1'b0;
      // read-only CTRL bits ignore writes, bit0=0 does not start
      do_aw_w(32'h0, 32'hFFFF_FFFE, 4'hF, 1, 0);
      model_write(8'h00, 32'hFFFF_FFFE, 4'hF);
      do_b(1, resp);
      do_read(32'h0, 0, rd, resp);
      n_checks++;
      if (rd !== m_read(8'h00) || resp !== 2'b00 || ap_start !== 1'b0) begin
         n_fail++; $display("FAIL ctrl_ro_bits: rdata=%h rresp=%b start=%b, required %h 00 0", rd, resp, ap_start, m_read(8'h00));
      end
   endtask

   task automatic test_done();
      logic [31:0] rd, exp;
      logic [1:0]  resp;
      ap_idle = 1'b1;
      ap_done = 1'b1;
      @(posedge clk); #1;
      ap_done = 1'b0;
      m_done = 1'b1;
      exp = m_read(8'h00);
      do_read(32'h0, 0, rd, resp);
      m_done = 1'b0;
      n_checks++;
      if (rd !== exp || rd !== 32'h0000_000A) begin
         n_fail++; $display("FAIL done_first_read: got %h, required %h", rd, exp);
      end
      exp = m_read(8'h00);
      do_read(32'h0, 0, rd, resp);
      n_checks++;
      if (rd !== exp) begin
         n_fail++; $display("FAIL done_second_read: got %h, required %h", rd, exp);
      end
      // ap_done in the same cycle as the clearing read handshake
      exp = m_read(8'h00);
      s_araddr = 32'h0; s_arvalid = 1'b1; ap_done = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_arready !== 1'b1) begin
         n_fail++; $display("FAIL done_race_arready: got %b, required 1", s_arready);
      end
      @(posedge clk); #1;
      s_arvalid = 1'b0; ap_done = 1'b0;
      m_done = 1'b1;
      n_checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== exp) begin
         n_fail++; $display("FAIL done_race_read: rvalid=%b rdata=%h, required 1 %h", s_rvalid, s_rdata, exp);
      end
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
      exp = m_read(8'h00);
      do_read(32'h0, 1, rd, resp);
      m_done = 1'b0;
      n_checks++;
      if (rd !== exp) begin
         n_fail++; $display("FAIL done_race_sticky: got %h, required %h", rd, exp);
      end
      ap_idle = 1'b0;
      exp = m_read(8'h00);
      do_read(32'h0, 0, rd, resp);
      n_checks++;
      if (rd !== exp) begin
         n_fail++; $display("FAIL done_idle_low: got %h, required %h", rd, exp);
      end
   endtask

   task automatic test_unmapped();
      logic [7:0]  bad [3];
      logic [31:0] rd;
      logic [1:0]  resp;
      bad[0] = 8'h80;
      bad[1] = 8'h10 + 8'(4 * NARGS);
      bad[2] = 8'h11;
      for (int k = 0; k < 3; k++) begin
         do_read({24'h0, bad[k]}, 0, rd, resp);
         n_checks++;
         if (rd !== 32'h0 || resp !== 2'b10) begin
            n_fail++; $display("FAIL unmapped_read %h: got %h/%b, required 00000000/10", bad[k], rd, resp);
         end
         do_aw_w({24'h0, bad[k]}, $urandom(), 4'hF, k, 0);
         do_b(0, resp);
         n_checks++;
         if (resp !== 2'b10) begin
            n_fail++; $display("FAIL unmapped_bresp %h: got %b, required 10", bad[k], resp);
         end
         n_checks++;
         if (args !== m_flat() || ap_start !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_no_change %h: args=%h start=%b, required %h 0", bad[k], args, ap_start, m_flat());
         end
      end
   endtask

   task automatic test_concurrent();
      logic [31:0] exp;
      logic [1:0]  resp;
      exp = m_read(8'h00);
      s_araddr = 32'h0; s_arvalid = 1'b1;
      s_awaddr = 32'h0; s_wdata = 32'h1; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      @(posedge clk); #1;
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      m_start = 1'b1;
      n_checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== exp) begin
         n_fail++; $display("FAIL concurrent_read_prewrite: rvalid=%b rdata=%h, required 1 %h", s_rvalid, s_rdata, exp);
      end
      n_checks++;
      if (s_bvalid !== 1'b1 || ap_start !== 1'b1) begin
         n_fail++; $display("FAIL concurrent_write: bvalid=%b start=%b, required 1 1", s_bvalid, ap_start);
      end
      resp = s_bresp;
      s_rready = 1'b1; s_bready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0; s_bready = 1'b0;
      ap_ready = 1'b1;
      @(posedge clk); #1;
      ap_ready = 1'b0;
      m_start = 1'b0;
      n_checks++;
      if (ap_start !== 1'b0 || resp !== 2'b00) begin
         n_fail++; $display("FAIL concurrent_after: start=%b bresp=%b, required 0 00", ap_start, resp);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic [1:0]  resp;
      // W only -> W_WAIT, read of arg0 with rready low -> R_DATA
      s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
      s_araddr = 32'h10; s_arvalid = 1'b1;
      @(posedge clk); #1;
      s_wvalid = 1'b0; s_arvalid = 1'b0;
      n_checks++;
      if (s_rvalid !== 1'b1 || s_awready !== 1'b1 || s_wready !== 1'b0) begin
         n_fail++; $display("FAIL mid_setup: rvalid=%b awready=%b wready=%b, required 1 1 0", s_rvalid, s_awready, s_wready);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({s_bvalid, s_rvalid, s_awready, s_arready, ap_start} !== 5'b0 || args !== '0 || s_rdata !== 32'h0) begin
         n_fail++; $display("FAIL mid_reset_now: b/r/aw/ar/start=%b args=%h rdata=%h, required 0", {s_bvalid, s_rvalid, s_awready, s_arready, ap_start}, args, s_rdata);
      end
      @(negedge clk) rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++;
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || args !== '0) begin
         n_fail++; $display("FAIL mid_no_stray_resp: bvalid=%b rvalid=%b args=%h, required 0 0 0", s_bvalid, s_rvalid, args);
      end
      do_aw_w(32'h10, 32'h0BAD_F00D, 4'hF, 0, 1);
      model_write(8'h10, 32'h0BAD_F00D, 4'hF);
      n_checks++;
      if (s_bvalid !== 1'b1 || args !== m_flat()) begin
         n_fail++; $display("FAIL mid_first_write: bvalid=%b args=%h, required 1 %h", s_bvalid, args, m_flat());
      end
      do_b(0, resp);
      do_read(32'h10, 0, rd, resp);
      n_checks++;
      if (rd !== m_read(8'h10) || resp !== 2'b00) begin
         n_fail++; $display("FAIL mid_first_read: got %h/%b, required %h/00", rd, resp, m_read(8'h10));
      end
   endtask

   initial begin
      rst = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b0;
      model_reset();
      test_reset();
      test_same_cycle();
      test_w_first();
      test_random();
      test_rdata_stable();
      test_start();
      test_done();
      test_unmapped();
      test_concurrent();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
